// File: rtl/trig_acq_writer_pkg.sv
// Shared types, default widths and the BRAM word packing helper for the
// trigger-driven acquisition writer.
package acq_pkg;

    localparam int unsigned DATA_W_DEF  = 14;
    localparam int unsigned ADDR_W_DEF  = 13;
    localparam int unsigned DELAY_W_DEF = 16;
    localparam int unsigned WORD_W      = 32;
    localparam int unsigned HALF_W      = WORD_W / 2;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        CAPTURE,
        DONE
    } acq_state_e;

    // Channel B lands in the upper half, channel A in the lower half.
    function automatic logic [WORD_W-1:0] pack_sample(
        input logic signed [HALF_W-1:0] a_ext,
        input logic signed [HALF_W-1:0] b_ext
    );
        return {b_ext, a_ext};
    endfunction

endpackage

// File: rtl/trig_acq_writer_pack.sv
// One-cycle registered sign-extension and packing of the two ADC channels
// into a single BRAM word.
module acq_sample_pack
    import acq_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] adc_a,
    input  logic signed [DATA_W-1:0] adc_b,
    output logic [WORD_W-1:0]        word
);

    logic [WORD_W-1:0] word_d;
    logic [WORD_W-1:0] word_q;

    always_comb begin
        word_d = pack_sample(HALF_W'(adc_a), HALF_W'(adc_b));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word = word_q;

endmodule

// File: rtl/trig_acq_writer.sv
// Trigger handshake responder: on trig_flag, waits a programmable delay,
// writes N packed ADC samples into BRAM, then acknowledges with write_finished.
module trig_acq_writer
    import acq_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DELAY_W = DELAY_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trig_flag,
    input  logic [ADDR_W:0]          num_samples,
    input  logic [DELAY_W-1:0]       delay,
    input  logic signed [DATA_W-1:0] adc_a,
    input  logic signed [DATA_W-1:0] adc_b,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic [WORD_W-1:0]        bram_din,
    output logic                     bram_we,
    output logic                     busy,
    output logic                     write_finished,
    output logic                     aborted
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(1) << ADDR_W;
    localparam logic [ADDR_W:0] ONE_N = (ADDR_W + 1)'(1);

    acq_state_e          state_d, state_q;
    logic [DELAY_W-1:0]  count_d, count_q;
    logic [ADDR_W:0]     n_d, n_q;
    logic [ADDR_W-1:0]   idx_d, idx_q;
    logic [ADDR_W-1:0]   addr_d, addr_q;
    logic                we_d, we_q;
    logic                busy_d, busy_q;
    logic                wf_d, wf_q;
    logic                aborted_d, aborted_q;

    logic [ADDR_W:0]     n_clamped;
    logic                last_write;

    assign n_clamped  = (num_samples > DEPTH) ? DEPTH : num_samples;
    assign last_write = ({1'b0, idx_q} == (n_q - ONE_N));

    // The packer registers the sample on the same edge that we/addr are
    // registered in CAPTURE, so word and address stay aligned.
    acq_sample_pack #(
        .DATA_W(DATA_W)
    ) u_pack (
        .clk  (clk),
        .rst  (rst),
        .adc_a(adc_a),
        .adc_b(adc_b),
        .word (bram_din)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        n_d       = n_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        busy_d    = 1'b0;
        wf_d      = 1'b0;
        aborted_d = aborted_q;

        case (state_q)
            IDLE: begin
                if (trig_flag) begin
                    n_d       = n_clamped;
                    count_d   = delay - DELAY_W'(1);
                    idx_d     = '0;
                    aborted_d = 1'b0;
                    if (n_clamped == '0) begin
                        state_d = DONE;
                    end else if (delay == '0) begin
                        state_d = CAPTURE;
                    end else begin
                        state_d = DELAY;
                    end
                end
            end

            DELAY: begin
                if (!trig_flag) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    if (count_q == '0) begin
                        state_d = CAPTURE;
                    end else begin
                        count_d = count_q - DELAY_W'(1);
                    end
                end
            end

            CAPTURE: begin
                if (!trig_flag) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                    addr_d = idx_q;
                    idx_d  = idx_q + ADDR_W'(1);
                    if (last_write) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (trig_flag) begin
                    wf_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            wf_q      <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            n_q       <= n_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            busy_q    <= busy_d;
            wf_q      <= wf_d;
            aborted_q <= aborted_d;
        end
    end

    assign bram_addr      = addr_q;
    assign bram_we        = we_q;
    assign busy           = busy_q;
    assign write_finished = wf_q;
    assign aborted        = aborted_q;

endmodule

// File: tb/tb_trig_acq_writer.sv
// Directed bench for trig_acq_writer: default-width instance plus a
// 4-bit-address instance for the sample-count clamp and mid-capture reset.
module tb_trig_acq_writer;

    logic               clk = 1'b0;
    logic               rst;
    logic               trig_flag;
    logic [13:0]        num_samples;
    logic [15:0]        delay;
    logic signed [13:0] adc_a;
    logic signed [13:0] adc_b;
    logic [12:0]        bram_addr;
    logic [31:0]        bram_din;
    logic               bram_we;
    logic               busy;
    logic               write_finished;
    logic               aborted;

    logic               trig_c;
    logic [4:0]         num_c;
    logic [3:0]         addr_c;
    logic [31:0]        din_c;
    logic               we_c;
    logic               busy_c;
    logic               wf_c;
    logic               aborted_c;

    int n_checks = 0;
    int n_fail   = 0;
    int sample_c = 0;

    always #5 clk = ~clk;

    trig_acq_writer dut (
        .clk           (clk),
        .rst           (rst),
        .trig_flag     (trig_flag),
        .num_samples   (num_samples),
        .delay         (delay),
        .adc_a         (adc_a),
        .adc_b         (adc_b),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_we       (bram_we),
        .busy          (busy),
        .write_finished(write_finished),
        .aborted       (aborted)
    );

    trig_acq_writer #(
        .ADDR_W(4)
    ) dut_c (
        .clk           (clk),
        .rst           (rst),
        .trig_flag     (trig_c),
        .num_samples   (num_c),
        .delay         (16'd0),
        .adc_a         (adc_a),
        .adc_b         (adc_b),
        .bram_addr     (addr_c),
        .bram_din      (din_c),
        .bram_we       (we_c),
        .busy          (busy_c),
        .write_finished(wf_c),
        .aborted       (aborted_c)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // adc_a = c, adc_b = -c; expected word is {16-bit -c, 16-bit c}.
    function automatic logic [31:0] exp_word(input int c);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(c);
        hi = 16'(0 - c);
        return {hi, lo};
    endfunction

    task automatic set_adc();
        adc_a = 14'(sample_c);
        adc_b = 14'(0 - sample_c);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        sample_c++;
        set_adc();
    endtask

    initial begin
        int c_prev;
        int writes;

        rst         = 1'b1;
        trig_flag   = 1'b0;
        num_samples = '0;
        delay       = '0;
        trig_c      = 1'b0;
        num_c       = '0;
        sample_c    = 1;
        set_adc();
        step();
        step();
        check("rst_we",      64'(bram_we),        64'd0);
        check("rst_addr",    64'(bram_addr),      64'd0);
        check("rst_din",     64'(bram_din),       64'd0);
        check("rst_busy",    64'(busy),           64'd0);
        check("rst_wf",      64'(write_finished), 64'd0);
        check("rst_aborted", 64'(aborted),        64'd0);
        rst = 1'b0;
        step();

        // Basic capture: N=4, D=0
        num_samples = 14'd4;
        delay       = 16'd0;
        trig_flag   = 1'b1;
        step();
        check("basic_k_we", 64'(bram_we), 64'd0);
        for (int i = 0; i < 4; i++) begin
            c_prev = sample_c;
            step();
            check("basic_we",   64'(bram_we),   64'd1);
            check("basic_addr", 64'(bram_addr), 64'(i));
            check("basic_din",  64'(bram_din),  64'(exp_word(c_prev)));
            check("basic_busy", 64'(busy),      64'd1);
            check("basic_wf0",  64'(write_finished), 64'd0);
        end
        step();
        check("basic_done_we",   64'(bram_we),        64'd0);
        check("basic_done_wf",   64'(write_finished), 64'd1);
        check("basic_done_busy", 64'(busy),           64'd0);
        step();
        check("basic_wf_hold", 64'(write_finished), 64'd1);
        trig_flag = 1'b0;
        step();
        check("basic_wf_drop", 64'(write_finished), 64'd0);
        step();

        // Delay: D=3, N=2
        num_samples = 14'd2;
        delay       = 16'd3;
        trig_flag   = 1'b1;
        step();
        check("dly_k_busy", 64'(busy), 64'd0);
        step();
        check("dly_k1_busy", 64'(busy),    64'd1);
        check("dly_k1_we",   64'(bram_we), 64'd0);
        step();
        check("dly_k2_we", 64'(bram_we), 64'd0);
        step();
        check("dly_k3_we", 64'(bram_we), 64'd0);
        num_samples = 14'd9;
        delay       = 16'd7;
        step();
        check("dly_k4_we",   64'(bram_we),   64'd1);
        check("dly_k4_addr", 64'(bram_addr), 64'd0);
        step();
        check("dly_k5_we",   64'(bram_we),   64'd1);
        check("dly_k5_addr", 64'(bram_addr), 64'd1);
        step();
        check("dly_k6_we", 64'(bram_we),        64'd0);
        check("dly_k6_wf", 64'(write_finished), 64'd1);
        trig_flag = 1'b0;
        step();
        check("dly_wf_drop", 64'(write_finished), 64'd0);

        // Zero samples
        num_samples = 14'd0;
        delay       = 16'd5;
        trig_flag   = 1'b1;
        step();
        check("zero_k_wf", 64'(write_finished), 64'd0);
        step();
        check("zero_wf",   64'(write_finished), 64'd1);
        check("zero_we",   64'(bram_we),        64'd0);
        check("zero_busy", 64'(busy),           64'd0);
        trig_flag = 1'b0;
        step();
        check("zero_wf_drop", 64'(write_finished), 64'd0);

        // Abort after 10 writes of a 100-sample capture
        num_samples = 14'd100;
        delay       = 16'd0;
        trig_flag   = 1'b1;
        step();
        writes = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bram_we) writes++;
            check("abort_addr", 64'(bram_addr), 64'(i));
        end
        check("abort_writes", 64'(writes), 64'd10);
        trig_flag = 1'b0;
        step();
        check("abort_we",      64'(bram_we),        64'd0);
        check("abort_flag",    64'(aborted),        64'd1);
        check("abort_busy",    64'(busy),           64'd0);
        check("abort_wf",      64'(write_finished), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_wf_idle",  64'(write_finished), 64'd0);
            check("abort_sticky",   64'(aborted),        64'd1);
        end
        num_samples = 14'd2;
        trig_flag   = 1'b1;
        step();
        check("rearm_clear", 64'(aborted), 64'd0);
        step();
        check("rearm_w0", 64'(bram_we), 64'd1);
        step();
        check("rearm_w1_addr", 64'(bram_addr), 64'd1);
        step();
        check("rearm_wf", 64'(write_finished), 64'd1);
        trig_flag = 1'b0;
        step();

        // Clamp on the 4-bit address instance: 20 requested, 16 written
        num_c  = 5'd20;
        trig_c = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            check("clamp_we",   64'(we_c),   64'd1);
            check("clamp_addr", 64'(addr_c), 64'(i));
        end
        step();
        check("clamp_end_we", 64'(we_c), 64'd0);
        check("clamp_end_wf", 64'(wf_c), 64'd1);
        trig_c = 1'b0;
        step();
        check("clamp_wf_drop", 64'(wf_c), 64'd0);

        // Reset mid-capture
        num_c  = 5'd8;
        trig_c = 1'b1;
        step();
        step();
        step();
        check("rstcap_we_pre", 64'(we_c),   64'd1);
        check("rstcap_addr_pre", 64'(addr_c), 64'd1);
        rst = 1'b1;
        step();
        check("rstcap_we",      64'(we_c),      64'd0);
        check("rstcap_addr",    64'(addr_c),    64'd0);
        check("rstcap_din",     64'(din_c),     64'd0);
        check("rstcap_busy",    64'(busy_c),    64'd0);
        check("rstcap_wf",      64'(wf_c),      64'd0);
        check("rstcap_aborted", 64'(aborted_c), 64'd0);
        rst    = 1'b0;
        trig_c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rstcap_idle_we", 64'(we_c), 64'd0);
            check("rstcap_idle_wf", 64'(wf_c), 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
